// File: rtl/rr_enc_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_enc_arbiter_pkg
//  Description : Shared constants and state encoding for the round-robin
//                encoded-grant arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package rr_enc_arbiter_pkg;

    localparam int N        = 8;
    localparam int IDXW     = 3;
    localparam int MAX_HOLD = 16;
    localparam int CW       = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_enc_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotating priority encoder; returns the first
//                set request at or after ptr, wrapping N-1 -> 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import rr_enc_arbiter_pkg::*;
(
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic            any,
    output logic [IDXW-1:0] win_idx
);

    localparam int PW = IDXW + 1;

    logic [PW-1:0] w_pos;

    always_comb begin
        any     = 1'b0;
        win_idx = '0;
        w_pos   = '0;
        for (int i = 0; i < N; i++) begin
            // One extra bit so the modulo-N wrap also works for non power-of-two N
            w_pos = PW'(ptr) + PW'(i);
            if (w_pos >= PW'(N)) begin
                w_pos = w_pos - PW'(N);
            end
            if (!any && req[w_pos[IDXW-1:0]]) begin
                any     = 1'b1;
                win_idx = w_pos[IDXW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_enc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_enc_arbiter
//  Description : Round-robin arbiter for N requesters with one-hot grant,
//                binary grant index and a hold-time limit with timeout pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_enc_arbiter
    import rr_enc_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_vld,
    output logic            timeout
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDXW-1:0] r_ptr;
    logic [IDXW-1:0] w_ptr_nxt;
    logic [IDXW-1:0] r_gnt_idx;
    logic [IDXW-1:0] w_gnt_idx_nxt;
    logic [N-1:0]    r_gnt;
    logic [N-1:0]    w_gnt_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            r_timeout;
    logic            w_timeout_nxt;

    logic            w_any;
    logic [IDXW-1:0] w_win_idx;
    logic            w_own;
    logic            w_at_limit;

    rr_pick u_pick (
        .req     (req),
        .ptr     (r_ptr),
        .any     (w_any),
        .win_idx (w_win_idx)
    );

    assign w_own      = req[r_gnt_idx];
    assign w_at_limit = (r_cnt == CW'(MAX_HOLD));

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_gnt_idx_nxt = r_gnt_idx;
        w_gnt_nxt     = r_gnt;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (en && w_any) begin
                    w_state_nxt   = BUSY;
                    w_gnt_nxt     = N'(1) << w_win_idx;
                    w_gnt_idx_nxt = w_win_idx;
                    w_cnt_nxt     = CW'(1);
                end
            end
            BUSY: begin
                if (w_own && en && !w_at_limit) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end else begin
                    // Any release rotates priority past the owner
                    w_state_nxt   = IDLE;
                    w_gnt_nxt     = '0;
                    w_gnt_idx_nxt = '0;
                    w_cnt_nxt     = '0;
                    w_ptr_nxt     = (r_gnt_idx == IDXW'(N - 1)) ? '0 : r_gnt_idx + IDXW'(1);
                    w_timeout_nxt = w_own && en && w_at_limit;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_gnt_nxt     = '0;
                w_gnt_idx_nxt = '0;
                w_cnt_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_gnt_idx <= '0;
            r_gnt     <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_gnt     <= w_gnt_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_idx = r_gnt_idx;
    assign gnt_vld = |r_gnt;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_enc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_enc_arbiter
//  Description : Self-checking bench for rr_enc_arbiter: directed vector
//                table, a timeout sequence and randomized reference checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_enc_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    rr_enc_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       to;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model state: owner -1 means no grant outstanding
    int   m_owner = -1;
    int   m_hold  = 0;
    int   m_ptr   = 0;
    bit   m_to    = 1'b0;

    function automatic void add(logic r, logic e, logic [7:0] q,
                                logic [7:0] g, logic [2:0] i, logic v, logic t);
        vec_t x;
        x.rst = r; x.en = e; x.req = q; x.gnt = g; x.idx = i; x.vld = v; x.to = t;
        vecs.push_back(x);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic model_step(logic r, logic e, logic [7:0] q);
        m_to = 1'b0;
        if (r) begin
            m_owner = -1; m_hold = 0; m_ptr = 0;
        end else if (m_owner < 0) begin
            if (e && q != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (m_owner < 0 && q[(m_ptr + k) % 8]) begin
                        m_owner = (m_ptr + k) % 8;
                        m_hold  = 1;
                    end
                end
            end
        end else if (q[m_owner] && e && m_hold < 16) begin
            m_hold++;
        end else begin
            m_to    = q[m_owner] && e;
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
            m_hold  = 0;
        end
    endtask

    function automatic logic [12:0] model_out();
        logic [7:0] g;
        logic [2:0] i;
        g = 8'h00;
        i = 3'd0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            i = 3'(m_owner);
        end
        return {g, i, (m_owner >= 0), m_to};
    endfunction

    initial begin
        int         hi;
        bit         seen;
        logic       inv_ok;
        logic [7:0] rq;
        logic [7:0] one;

        rst = 1'b1; en = 1'b0; req = 8'h00;

        // Basic grant / release, pointer moves to 1
        add(1, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 1, 8'h01, 8'h01, 0, 1, 0);
        add(0, 1, 8'h01, 8'h01, 0, 1, 0);
        add(0, 1, 8'h01, 8'h01, 0, 1, 0);
        add(0, 1, 8'h00, 8'h00, 0, 0, 0);
        add(0, 1, 8'h03, 8'h02, 1, 1, 0);
        add(0, 1, 8'h00, 8'h00, 0, 0, 0);
        // Fairness between 0 and 7, including 7 -> 0 wrap
        add(1, 1, 8'h00, 8'h00, 0, 0, 0);
        for (int r = 0; r < 2; r++) begin
            add(0, 1, 8'h81, 8'h01, 0, 1, 0);
            add(0, 1, 8'h81, 8'h01, 0, 1, 0);
            add(0, 1, 8'h80, 8'h00, 0, 0, 0);
            add(0, 1, 8'h81, 8'h80, 7, 1, 0);
            add(0, 1, 8'h81, 8'h80, 7, 1, 0);
            add(0, 1, 8'h01, 8'h00, 0, 0, 0);
        end
        add(0, 1, 8'h41, 8'h01, 0, 1, 0);
        add(0, 1, 8'h40, 8'h00, 0, 0, 0);
        add(0, 1, 8'h40, 8'h40, 6, 1, 0);
        add(0, 1, 8'h00, 8'h00, 0, 0, 0);
        // Timeout after exactly 16 held cycles, then regrant after one bubble
        for (int c = 0; c < 16; c++) add(0, 1, 8'h04, 8'h04, 2, 1, 0);
        add(0, 1, 8'h04, 8'h00, 0, 0, 1);
        add(0, 1, 8'h04, 8'h04, 2, 1, 0);
        // Enable low forces release without timeout; no grant while low
        add(0, 0, 8'h04, 8'h00, 0, 0, 0);
        add(0, 0, 8'h04, 8'h00, 0, 0, 0);
        add(0, 1, 8'h04, 8'h04, 2, 1, 0);
        // Reset mid-grant, pointer back to 0 (ptr 3 would pick idx 3)
        add(1, 1, 8'h04, 8'h00, 0, 0, 0);
        add(0, 1, 8'h0C, 8'h04, 2, 1, 0);
        add(0, 1, 8'h00, 8'h00, 0, 0, 0);
        // Single-requester sweep
        for (int b = 0; b < 8; b++) begin
            one = 8'h01 << b;
            add(0, 1, one, one, 3'(b), 1, 0);
            add(0, 1, 8'h00, 8'h00, 0, 0, 0);
        end
        // Limit reached while enable drops: not a timeout
        for (int c = 0; c < 16; c++) add(0, 1, 8'h10, 8'h10, 4, 1, 0);
        add(0, 0, 8'h10, 8'h00, 0, 0, 0);
        add(0, 1, 8'h10, 8'h10, 4, 1, 0);
        add(0, 1, 8'h00, 8'h00, 0, 0, 0);

        foreach (vecs[k]) begin
            rst = vecs[k].rst; en = vecs[k].en; req = vecs[k].req;
            @(posedge clk); #1;
            check($sformatf("vec%0d", k), {gnt, gnt_idx, gnt_vld, timeout},
                  {vecs[k].gnt, vecs[k].idx, vecs[k].vld, vecs[k].to});
        end

        // Held request: count grant cycles until the timeout pulse, bounded wait
        rst = 1'b0; en = 1'b1; req = 8'h20;
        hi = 0; seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clk); #1;
            if (gnt == 8'h20) hi++;
            if (timeout) seen = 1'b1;
        end
        check("to_seen", 32'(seen), 32'd1);
        check("to_hold_len", 32'(hi), 32'd16);
        check("to_gnt_dropped", 32'(gnt), 32'h00);
        @(posedge clk); #1;
        check("to_regrant", {gnt, gnt_idx, timeout}, {8'h20, 3'd5, 1'b0});
        req = 8'h00;
        @(posedge clk); #1;
        check("to_release", 32'(gnt), 32'h00);

        // Randomized run against the reference model
        rq = 8'h00;
        for (int c = 0; c < 800; c++) begin
            if (c == 0) rst = 1'b1;
            else        rst = ($urandom_range(0, 149) == 0);
            en = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 5) == 0) begin
                rq = 8'($urandom);
                if ($urandom_range(0, 1) == 0) rq = rq & 8'($urandom);
            end
            req = rq;
            model_step(rst, en, req);
            @(posedge clk); #1;
            check($sformatf("rnd%0d", c), {gnt, gnt_idx, gnt_vld, timeout}, model_out());
            inv_ok = ($countones(gnt) <= 1) && (gnt_vld == (|gnt)) &&
                     (gnt == (gnt_vld ? (8'h01 << gnt_idx) : 8'h00));
            check($sformatf("inv%0d", c), 32'(inv_ok), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_enc_arbiter.md
Name: rr_enc_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among 8 requesters.
- Produces a one-hot grant plus its 3-bit binary index, i.e. the encoded form the existing 8-to-3 encoder datapath consumes.
- Holds each grant until the owner releases it or a hold-time limit expires; then rotates priority.
- Sits in front of the shared resource; requesters drive req lines and watch their grant bit.

Parameters:
- N, 8, number of requesters.
- IDXW, 3, grant index width (log2 N).
- MAX_HOLD, 16, maximum consecutive cycles one grant may be held before forced release (must be >= 1).
- CW, 5, hold-counter width (must hold MAX_HOLD).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  arbiter enable; no new grant is issued while low.
- req  input  N  request vector, bit i = requester i.
- gnt  output  N  one-hot grant, registered.
- gnt_idx  output  IDXW  binary index of the set gnt bit; 0 when gnt_vld = 0.
- gnt_vld  output  1  a grant is active (equals |gnt).
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (rst = 1 at a clk edge):
  - gnt = 0, gnt_idx = 0, gnt_vld = 0, timeout = 0.
  - Priority pointer ptr = 0; hold counter = 0; state = IDLE.
  - Reset overrides everything, including mid-grant; the grant drops at that edge.
- States:
  - IDLE: no grant outstanding.
  - BUSY: exactly one gnt bit set.
- IDLE, en = 1 and req != 0:
  - Winner = first set req bit scanning ptr, ptr+1, ..., wrapping N-1 -> 0.
  - Next edge: gnt = one-hot(winner), gnt_idx = winner, gnt_vld = 1, counter = 1, state = BUSY.
  - Latency is 1 cycle from req sampled to grant visible.
- IDLE, en = 0 or req = 0: remain IDLE, outputs held at their reset values.
- BUSY: grant held while req[gnt_idx] = 1, en = 1 and counter < MAX_HOLD; counter increments each held cycle.
- BUSY release conditions (evaluated each edge):
  - req[gnt_idx] = 0 (voluntary release).
  - en = 0 (forced).
  - counter == MAX_HOLD with req still high (timeout).
- BUSY release action at the next edge:
  - gnt = 0, gnt_vld = 0, gnt_idx = 0, counter = 0, state = IDLE.
  - ptr = gnt_idx + 1 mod N (7 wraps to 0).
  - timeout = 1 for that one cycle only if the timeout condition was the cause; otherwise 0.
- Simultaneous release causes: the pointer still advances; timeout is asserted only when counter == MAX_HOLD and req and en are both still high.
- Minimum one IDLE cycle between consecutive grants (bubble cycle). A timed-out requester may win again only after the others in rotation order.
- Requests from other requesters during BUSY are ignored (no preemption). A requester's req may drop before it is granted without consequence.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_idx is always the binary encoding of gnt.
  - gnt changes only at a clk edge.

Decomposition:
- Shared package holds:
  - constants N, IDXW, MAX_HOLD.
  - state encoding (IDLE = 1'b0, BUSY = 1'b1).
- One natural sub-module, rr_pick: combinational rotating priority encoder.
  - Inputs: req[N-1:0], ptr[IDXW-1:0].
  - Outputs: any (1 bit), win_idx[IDXW-1:0].
  - The top level holds the FSM, pointer, counter and output registers.

Test Plan:
- Reset then en = 1, req = 8'h01 held 3 cycles, then dropped -> gnt = 8'h01 / idx 0 one cycle after req; gnt clears one cycle after the drop; ptr = 1.
- Fairness: ptr = 0, req = 8'h81 constant, each owner releases after 2 cycles -> grants alternate idx 0, 7, 0, 7 with one idle cycle between each.
- Wrap: grant idx 7, release -> ptr = 0; next req = 8'h41 -> idx 0 granted before 6.
- Timeout: req = 8'h04 held high -> gnt = 8'h04 for exactly 16 cycles; timeout pulses once; gnt drops; the same requester is regranted after 1 idle cycle (sole requester).
- Enable/reset: mid-grant en = 0 -> grant drops next edge, timeout = 0. Separate run with rst = 1 mid-grant -> all outputs 0 at that edge, ptr = 0.
- Sweep: req = 8'h01, 02, 04, ..., 80 one at a time -> gnt_idx = 0..7 and gnt equals req each time.
